// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the pipe_ctrl sequencer.
// PIPE_CTRL_PERF_EN adds the performance counter signals.
interface pipe_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        recovering;
  logic        stall_timeout;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [15:0] perf_flush_cnt;
`endif

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i,
`ifdef PIPE_CTRL_PERF_EN
    input  perf_stall_cnt, perf_flush_cnt,
`endif
    input  stall, flush, new_pc, recovering, stall_timeout
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i,
`ifdef PIPE_CTRL_PERF_EN
    output perf_stall_cnt, perf_flush_cnt,
`endif
    output stall, flush, new_pc, recovering, stall_timeout
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall merge, exception flush/redirect, recovery window, stall watchdog.
// Define PIPE_CTRL_PERF_EN to add the stall/flush performance counters.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR     = 32'h0000_0020,
  parameter int          RECOVER_CYCLES = 2,
  parameter int          STALL_LIMIT    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic {RUN, RECOVER} state_t;

  localparam logic [3:0]  REC_LOAD = 4'(RECOVER_CYCLES);
  localparam logic [15:0] WD_LAST  = 16'(STALL_LIMIT - 1);
  localparam logic [31:0] ERET     = 32'h0000_000e;

  state_t      state;
  logic [3:0]  rec_cnt;
  logic [15:0] wd_cnt;
  logic        timeout_p1;

  logic        exc_take;
  logic [5:0]  stall_req;
  logic [5:0]  stall_c;
  logic [31:0] new_pc_c;

  // Stage 0: combinational stall priority and exception decode
  always_comb begin
    stall_req = 6'b000000;
    if (bus.stallreq_mem)
      stall_req = 6'b011111;
    else if (bus.stallreq_ex)
      stall_req = 6'b001111;
    else if (bus.stallreq_id || bus.stallreq_if)
      stall_req = 6'b000111;

    exc_take = !rst && (state == RUN) && (bus.excepttype_i != 32'h0);
    // A flush clears every register, so any hold request is moot
    stall_c  = (rst || exc_take) ? 6'b000000 : stall_req;

    new_pc_c = 32'h0;
    if (exc_take)
      new_pc_c = (bus.excepttype_i == ERET) ? bus.cp0_epc_i : EXC_VECTOR;
  end

  assign bus.stall         = stall_c;
  assign bus.flush         = exc_take;
  assign bus.new_pc        = new_pc_c;
  assign bus.recovering    = (state == RECOVER) && !rst;
  assign bus.stall_timeout = timeout_p1 && !rst;

  // Stage 1: state, recovery window and watchdog registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      rec_cnt    <= 4'd0;
      wd_cnt     <= 16'd0;
      timeout_p1 <= 1'b0;
    end else begin
      timeout_p1 <= 1'b0;

      case (state)
        RUN: begin
          if (exc_take) begin
            state   <= RECOVER;
            rec_cnt <= REC_LOAD;
          end
        end
        RECOVER: begin
          // A held fetch does not consume the window
          if (!stall_c[0]) begin
            if (rec_cnt <= 4'd1) begin
              state   <= RUN;
              rec_cnt <= 4'd0;
            end else begin
              rec_cnt <= rec_cnt - 4'd1;
            end
          end
        end
        default: begin
          state   <= RUN;
          rec_cnt <= 4'd0;
        end
      endcase

      if (exc_take || (stall_c == 6'b000000)) begin
        wd_cnt <= 16'd0;
      end else if (wd_cnt == WD_LAST) begin
        wd_cnt     <= 16'd0;
        timeout_p1 <= 1'b1;
      end else begin
        wd_cnt <= wd_cnt + 16'd1;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_p1;
  logic [15:0] perf_flush_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_p1 <= 32'd0;
      perf_flush_p1 <= 16'd0;
    end else begin
      if (stall_c != 6'b000000)
        perf_stall_p1 <= perf_stall_p1 + 32'd1;
      if (exc_take)
        perf_flush_p1 <= perf_flush_p1 + 16'd1;
    end
  end

  assign bus.perf_stall_cnt = perf_stall_p1;
  assign bus.perf_flush_cnt = perf_flush_p1;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: driver pushes hand-computed expectations, monitor pops and compares.
module tb_pipe_ctrl;
  logic clk;
  logic rst;

  pipe_ctrl_if bus ();

  pipe_ctrl #(
    .EXC_VECTOR     (32'h0000_0020),
    .RECOVER_CYCLES (2),
    .STALL_LIMIT    (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        rec;
    logic        to;
    string       name;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor samples on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.name, ".stall"},   {26'h0, bus.stall},         {26'h0, e.stall});
      chk({e.name, ".flush"},   {31'h0, bus.flush},         {31'h0, e.flush});
      chk({e.name, ".new_pc"},  bus.new_pc,                 e.pc);
      chk({e.name, ".recov"},   {31'h0, bus.recovering},    {31'h0, e.rec});
      chk({e.name, ".timeout"}, {31'h0, bus.stall_timeout}, {31'h0, e.to});
    end
  end

  // req bits: {mem, ex, id, if}
  task automatic v(input logic r, input logic [3:0] req, input logic [31:0] exc,
                   input logic [31:0] epc, input logic [5:0] es, input logic ef,
                   input logic [31:0] ep, input logic er, input logic et, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst              = r;
    bus.stallreq_mem = req[3];
    bus.stallreq_ex  = req[2];
    bus.stallreq_id  = req[1];
    bus.stallreq_if  = req[0];
    bus.excepttype_i = exc;
    bus.cp0_epc_i    = epc;
    e.stall = es; e.flush = ef; e.pc = ep; e.rec = er; e.to = et; e.name = nm;
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    bus.stallreq_if = 1'b0; bus.stallreq_id = 1'b0;
    bus.stallreq_ex = 1'b0; bus.stallreq_mem = 1'b0;
    bus.excepttype_i = 32'h0; bus.cp0_epc_i = 32'h0;

    v(1, 4'b1000, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0, 0, "reset0");
    v(1, 4'b1000, 32'hc, 32'h0, 6'b000000, 0, 32'h0, 0, 0, "reset1");
    v(0, 4'b0110, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 0, 0, "prio_id_ex");
    v(0, 4'b0010, 32'h0, 32'h0, 6'b000111, 0, 32'h0, 0, 0, "prio_id");
    v(0, 4'b0000, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0, 0, "idle0");

    v(0, 4'b1000, 32'hc, 32'h0, 6'b000000, 1, 32'h20, 0, 0, "exc_c_mem");
    v(0, 4'b0000, 32'h8, 32'h0, 6'b000000, 0, 32'h0, 1, 0, "recov1_ign");
    v(0, 4'b0000, 32'h9, 32'h0, 6'b000000, 0, 32'h0, 1, 0, "recov2_ign");
    v(0, 4'b0000, 32'he, 32'h0040_0124, 6'b000000, 1, 32'h0040_0124, 0, 0, "eret_run");

    v(0, 4'b0001, 32'h1, 32'h0, 6'b000111, 0, 32'h0, 1, 0, "recov_if1");
    v(0, 4'b0001, 32'h0, 32'h0, 6'b000111, 0, 32'h0, 1, 0, "recov_if2");
    v(0, 4'b0000, 32'h5, 32'h0, 6'b000000, 0, 32'h0, 1, 0, "recov_ext1");
    v(0, 4'b0000, 32'h5, 32'h0, 6'b000000, 0, 32'h0, 1, 0, "recov_ext2");
    v(0, 4'b0000, 32'h33, 32'h0040_0124, 6'b000000, 1, 32'h20, 0, 0, "exc_other");
    v(0, 4'b0000, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 1, 0, "recov_a");
    v(0, 4'b0000, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 1, 0, "recov_b");
    v(0, 4'b0000, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0, 0, "run_again");

    for (int i = 0; i < 8; i++)
      v(0, 4'b0100, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 0, 0, "wd_hold");
    v(0, 4'b0000, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0, 1, "wd_pulse");
    v(0, 4'b0000, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0, 0, "wd_once");

    for (int i = 0; i < 7; i++)
      v(0, 4'b0100, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 0, 0, "wd_gap_a");
    v(0, 4'b0000, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0, 0, "wd_gap");
    for (int i = 0; i < 7; i++)
      v(0, 4'b0100, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 0, 0, "wd_gap_b");
    v(0, 4'b0000, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0, 0, "wd_nopulse");

    v(0, 4'b0000, 32'ha, 32'h0, 6'b000000, 1, 32'h20, 0, 0, "exc_a");
    v(0, 4'b1000, 32'h0, 32'h0, 6'b011111, 0, 32'h0, 1, 0, "recov_mem");
    v(1, 4'b1000, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0, 0, "rst_mid");
    v(0, 4'b1000, 32'h0, 32'h0, 6'b011111, 0, 32'h0, 0, 0, "post_rst");
    v(0, 4'b1000, 32'hd, 32'h0, 6'b000000, 1, 32'h20, 0, 0, "post_rst_exc");
    v(0, 4'b0000, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 1, 0, "post_rst_rec");

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(posedge clk);
    if (q.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
